// File: rtl/temp_alert_trigger.sv
// temp_alert_trigger
// Watches a stream of signed temperature samples and issues a single-cycle
// control pulse to the LED flasher once CONFIRM consecutive samples are
// above threshold. After firing it waits for the flasher display period
// (SYS_FREQ*HOLDOFF cycles). It re-arms only when a sample falls to
// threshold-HYST or below.
//
// Handshake: temp_valid is a one-cycle strobe with no back-pressure. A sample
// is consumed on every rising edge where temp_valid is high. Samples arriving
// outside IDLE/REARM are ignored. control is a one-cycle pulse that is never
// acknowledged.
module temp_alert_trigger #(
  parameter int SYS_FREQ = 100000000,
  parameter int HOLDOFF  = 20,
  parameter int CONFIRM  = 4,
  parameter int TEMP_W   = 16,
  parameter int HYST     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [TEMP_W-1:0]              temp_data,
  input  logic                           temp_valid,
  input  logic [TEMP_W-1:0]              threshold,
  output logic                           control,
  output logic                           alert_active,
  output logic [$clog2(CONFIRM+1)-1:0]   over_count
);

  localparam int          CNT_W      = $clog2(CONFIRM + 1);
  localparam logic [63:0] MAX_WIDE   = 64'(SYS_FREQ) * 64'(HOLDOFF);
  localparam logic [31:0] MAX        = MAX_WIDE[31:0];
  localparam logic [31:0] TIMER_LAST = MAX - 32'd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM - 1);
  localparam logic signed [TEMP_W:0] HYST_X = (TEMP_W + 1)'(HYST);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FIRE    = 2'd1,
    S_HOLDOFF = 2'd2,
    S_REARM   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         timer_q, timer_d;

  // One extra bit so threshold-HYST cannot wrap at the bottom of the range.
  logic signed [TEMP_W:0] temp_ext;
  logic signed [TEMP_W:0] thr_ext;
  logic signed [TEMP_W:0] clear_lvl;
  logic                   is_over;
  logic                   is_clear;

  assign temp_ext  = {temp_data[TEMP_W-1], temp_data};
  assign thr_ext   = {threshold[TEMP_W-1], threshold};
  assign clear_lvl = thr_ext - HYST_X;
  assign is_over   = temp_ext > thr_ext;
  assign is_clear  = temp_ext <= clear_lvl;

  // State, run counter and holdoff timer registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic: count the over-threshold run, fire, hold off, wait for clear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (temp_valid) begin
          if (is_over) begin
            if (cnt_q == CNT_LAST) begin
              state_d = S_FIRE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      S_FIRE: begin
        cnt_d   = '0;
        timer_d = '0;
        state_d = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        cnt_d = '0;
        if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          state_d = S_REARM;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_REARM: begin
        cnt_d = '0;
        if (temp_valid && is_clear) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        timer_d = '0;
      end
    endcase
  end

  // Outputs decode directly from the registered state.
  always_comb begin
    control      = (state_q == S_FIRE);
    alert_active = (state_q != S_IDLE);
    over_count   = cnt_q;
  end

endmodule
